// File: rtl/de2_115_web_qsys_pio_pkg.sv
// Shared constants and types for the switch-PIO interrupt master.
// Holds PIO word addresses, the service FSM state enum and the default width.
package de2_115_web_qsys_pio_pkg;

  localparam int WIDTH_DEF = 18;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_CAP,
    ST_CLR,
    ST_RD_DAT,
    ST_EMIT
  } state_e;

endpackage

// File: rtl/de2_115_web_qsys_avm_xfer.sv
// Single-transfer Avalon-MM master engine: one read or write per start pulse.
// Ports: start_i/wr_i/addr_i/wdata_i request, busy_o/done_o/rdata_o result,
// avm_* bus side. done_o pulses on write acceptance or on the read sample cycle.
module de2_115_web_qsys_avm_xfer #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        wr_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic [1:0]  avm_address_o,
  output logic        avm_read_o,
  output logic        avm_write_o,
  output logic [31:0] avm_writedata_o,
  input  logic [31:0] avm_readdata_i,
  input  logic        avm_waitrequest_i
);

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [1:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        accept;

  always_comb begin
    accept = (rd_q | wr_q) & ~avm_waitrequest_i;
    rd_d   = rd_q;
    wr_d   = wr_q;
    addr_d = addr_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
    if (accept) begin
      rd_d = 1'b0;
      wr_d = 1'b0;
      // read data is due LAT cycles after acceptance
      if (rd_q) cnt_d = LAT;
    end
    // a new start may coincide with the done of the previous transfer
    if (start_i) begin
      rd_d   = ~wr_i;
      wr_d   = wr_i;
      addr_d = addr_i;
      data_d = wr_i ? wdata_i : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= 2'd0;
      data_q <= 32'd0;
      cnt_q  <= 3'd0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o          = rd_q | wr_q | (cnt_q != 3'd0);
  assign done_o          = (wr_q & accept) | (cnt_q == 3'd1);
  assign rdata_o         = avm_readdata_i;
  assign avm_address_o   = addr_q;
  assign avm_read_o      = rd_q;
  assign avm_write_o     = wr_q;
  assign avm_writedata_o = data_q;

endmodule

// File: rtl/de2_115_web_qsys_pio_irq_master.sv
// Services the edge-capturing switch PIO on irq and emits one event per edge set.
// Ports: clk/reset, irq, avm_* master bus, cfg_mask_* mask update, evt_* stream.
module de2_115_web_qsys_pio_irq_master
  import de2_115_web_qsys_pio_pkg::*;
#(
  parameter int               WIDTH        = WIDTH_DEF,
  parameter int               READ_LATENCY = 1,
  parameter logic [WIDTH-1:0] MASK_INIT    = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  output logic             avm_write,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_waitrequest,
  input  logic             cfg_mask_wr,
  input  logic [WIDTH-1:0] cfg_mask,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_level,
  output logic [15:0]      evt_count
);

  state_e           st_q, st_d;
  logic [WIDTH-1:0] edges_q, edges_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] pmask_q, pmask_d;
  logic             pend_q, pend_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             x_start, x_wr, x_done, x_busy;
  logic [1:0]       x_addr;
  logic [31:0]      x_wdata, x_rdata;
  logic [WIDTH-1:0] rd_w;
  logic             unused_rd;

  assign rd_w      = x_rdata[WIDTH-1:0];
  assign unused_rd = ^x_rdata;

  de2_115_web_qsys_avm_xfer #(
    .READ_LATENCY(READ_LATENCY)
  ) u_xfer (
    .clk               (clk),
    .reset             (reset),
    .start_i           (x_start),
    .wr_i              (x_wr),
    .addr_i            (x_addr),
    .wdata_i           (x_wdata),
    .busy_o            (x_busy),
    .done_o            (x_done),
    .rdata_o           (x_rdata),
    .avm_address_o     (avm_address),
    .avm_read_o        (avm_read),
    .avm_write_o       (avm_write),
    .avm_writedata_o   (avm_writedata),
    .avm_readdata_i    (avm_readdata),
    .avm_waitrequest_i (avm_waitrequest)
  );

  always_comb begin
    st_d    = st_q;
    edges_d = edges_q;
    level_d = level_q;
    mask_d  = mask_q;
    pmask_d = pmask_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    x_start = 1'b0;
    x_wr    = 1'b0;
    x_addr  = PIO_ADDR_DATA;
    x_wdata = 32'd0;
    // last pulse wins until the update is taken from IDLE
    if (cfg_mask_wr) begin
      pend_d  = 1'b1;
      pmask_d = cfg_mask;
    end
    unique case (st_q)
      ST_INIT: begin
        if (x_done) begin
          st_d = ST_IDLE;
        end else if (!x_busy) begin
          x_start = 1'b1;
          x_wr    = 1'b1;
          x_addr  = PIO_ADDR_MASK;
          x_wdata[WIDTH-1:0] = mask_q;
        end
      end
      ST_IDLE: begin
        if (pend_q) begin
          st_d   = ST_INIT;
          mask_d = pmask_q;
          if (!cfg_mask_wr) pend_d = 1'b0;
        end else if (irq) begin
          st_d    = ST_RD_CAP;
          x_start = 1'b1;
          x_addr  = PIO_ADDR_EDGE;
        end
      end
      ST_RD_CAP: begin
        if (x_done) begin
          edges_d = rd_w;
          if (rd_w == '0) begin
            st_d = ST_IDLE;
          end else begin
            st_d    = ST_CLR;
            x_start = 1'b1;
            x_wr    = 1'b1;
            x_addr  = PIO_ADDR_EDGE;
            x_wdata[WIDTH-1:0] = rd_w;
          end
        end
      end
      ST_CLR: begin
        if (x_done) begin
          st_d    = ST_RD_DAT;
          x_start = 1'b1;
          x_addr  = PIO_ADDR_DATA;
        end
      end
      ST_RD_DAT: begin
        if (x_done) begin
          level_d = rd_w;
          st_d    = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (evt_ready) begin
          cnt_d = cnt_q + 16'd1;
          st_d  = ST_IDLE;
        end
      end
      default: st_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= ST_INIT;
      edges_q <= '0;
      level_q <= '0;
      mask_q  <= MASK_INIT;
      pmask_q <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      st_q    <= st_d;
      edges_q <= edges_d;
      level_q <= level_d;
      mask_q  <= mask_d;
      pmask_q <= pmask_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign evt_valid = (st_q == ST_EMIT);
  assign evt_edges = edges_q;
  assign evt_level = level_q;
  assign evt_count = cnt_q;

endmodule

// File: tb/tb_de2_115_web_qsys_pio_irq_master.sv
// Bench for the PIO interrupt master: a behavioural PIO slave with stalls,
// read latency and edge capture, driven by per-scenario tasks.
module tb_de2_115_web_qsys_pio_irq_master;

  localparam int W = 18;
  localparam int L = 1;
  localparam logic [W-1:0] ALL1 = '1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          irq = 1'b0;
  wire  [1:0]    avm_address;
  wire           avm_read, avm_write;
  wire  [31:0]   avm_writedata;
  logic [31:0]   avm_readdata = 32'd0;
  logic          avm_waitrequest = 1'b0;
  logic          cfg_mask_wr = 1'b0;
  logic [W-1:0]  cfg_mask = '0;
  wire           evt_valid;
  logic          evt_ready = 1'b1;
  wire  [W-1:0]  evt_edges, evt_level;
  wire  [15:0]   evt_count;

  de2_115_web_qsys_pio_irq_master #(.WIDTH(W), .READ_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .irq(irq),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .cfg_mask_wr(cfg_mask_wr), .cfg_mask(cfg_mask),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_edges(evt_edges), .evt_level(evt_level), .evt_count(evt_count)
  );

  typedef struct {int c; bit wr; logic [1:0] a; logic [31:0] d;} xact_t;
  xact_t log_q[$];

  int checks = 0, passes = 0;
  int cyc = 0;
  logic [W-1:0] cap = '0, lvl = '0, pio_mask = '0;
  int stall_cfg = 0;
  bit force_irq = 1'b0;
  logic [W-1:0] inj_val = '0;
  int inj_seq = 0, inj_seen = 0;
  int irq_rise = -1, vrise = -1, hold_err = 0, stab_err = 0;
  logic [15:0] exp_count = 16'd0;

  // PIO slave model state
  int stall_left = 0, rd_due = -100;
  logic [31:0] rd_val = 32'd0;
  bit prev_st = 1'b0, vprev = 1'b0, req, wq, irq_n;
  logic [35:0] snap = '0;
  logic [W-1:0] pe = '0, pl = '0;
  xact_t xe;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (inj_seq != inj_seen) begin
      cap = cap | inj_val;
      inj_seen = inj_seq;
    end
    irq_n = (|(cap & pio_mask)) || force_irq;
    if (irq_n && !irq) irq_rise = cyc;
    irq = irq_n;
    if (reset) begin
      stall_left = 0; prev_st = 1'b0; rd_due = -100;
      avm_waitrequest = 1'b0; vprev = 1'b0;
    end else begin
      req = avm_read || avm_write;
      if (avm_read && avm_write) stab_err++;
      if (req && prev_st &&
          snap !== {avm_read, avm_write, avm_address, avm_writedata})
        stab_err++;
      if (req && !prev_st) stall_left = stall_cfg;
      wq = req && (stall_left > 0);
      if (wq) stall_left--;
      avm_waitrequest = wq;
      if (req && !wq) begin
        xe.c = cyc; xe.wr = avm_write; xe.a = avm_address; xe.d = avm_writedata;
        log_q.push_back(xe);
        if (avm_write) begin
          if (avm_address == 2'd2) pio_mask = avm_writedata[W-1:0];
          if (avm_address == 2'd3) cap = '0;
        end else begin
          rd_due = cyc + L;
          rd_val = $urandom();
          if (avm_address == 2'd3) rd_val[W-1:0] = cap;
          else if (avm_address == 2'd0) rd_val[W-1:0] = lvl;
        end
      end
      prev_st = wq;
      snap = {avm_read, avm_write, avm_address, avm_writedata};
      if (evt_valid && !vprev) vrise = cyc;
      if (evt_valid && vprev && (evt_edges !== pe || evt_level !== pl)) hold_err++;
      vprev = evt_valid; pe = evt_edges; pl = evt_level;
    end
    avm_readdata = (cyc == rd_due) ? rd_val : $urandom();
  end

  task automatic inject(input logic [W-1:0] v);
    inj_val = v;
    inj_seq++;
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      ok = evt_valid;
    end
  endtask

  task automatic test_reset();
    int base, rel;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({avm_read, avm_write, avm_address, avm_writedata} !== 36'd0)
      $display("FAIL rst_bus got %h want 0", {avm_read, avm_write, avm_address, avm_writedata});
    else passes++;
    checks++;
    if ({evt_valid, evt_edges, evt_level, evt_count} !== '0)
      $display("FAIL rst_evt got v=%b e=%h l=%h c=%h want 0", evt_valid, evt_edges, evt_level, evt_count);
    else passes++;
    base = log_q.size();
    reset = 1'b0;
    rel = cyc;
    exp_count = 16'd0;
    repeat (8) @(negedge clk);
    checks++;
    if (log_q.size() - base != 1)
      $display("FAIL rst_nxact got %0d want 1", log_q.size() - base);
    else passes++;
    if (log_q.size() - base >= 1) begin
      checks++;
      if (log_q[base].wr !== 1'b1 || log_q[base].a !== 2'd2 || log_q[base].d !== 32'(ALL1))
        $display("FAIL rst_maskwr got wr=%0d a=%0d d=%h want wr=1 a=2 d=%h",
                 log_q[base].wr, log_q[base].a, log_q[base].d, 32'(ALL1));
      else passes++;
      checks++;
      if (log_q[base].c != rel + 1)
        $display("FAIL rst_maskcyc got %0d want %0d", log_q[base].c - rel, 1);
      else passes++;
    end
  endtask

  task automatic test_event();
    logic [W-1:0] e, lv;
    int base;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin e = W'(5); lv = W'(32'h3FFFA); end
      else begin
        e = W'($urandom_range(1, (1 << W) - 1));
        lv = W'($urandom());
      end
      lvl = lv;
      evt_ready = 1'b1;
      base = log_q.size();
      inject(e);
      wait_valid(40, ok);
      checks++;
      if (!ok) $display("FAIL ev%0d_timeout got no evt_valid want evt_valid", k);
      else passes++;
      checks++;
      if (vrise - irq_rise != 4 + 2 * L)
        $display("FAIL ev%0d_lat got %0d want %0d", k, vrise - irq_rise, 4 + 2 * L);
      else passes++;
      checks++;
      if (evt_edges !== e || evt_level !== lv)
        $display("FAIL ev%0d_data got e=%h l=%h want e=%h l=%h", k, evt_edges, evt_level, e, lv);
      else passes++;
      @(negedge clk);
      exp_count++;
      checks++;
      if (evt_count !== exp_count || evt_valid !== 1'b0)
        $display("FAIL ev%0d_count got c=%0d v=%b want c=%0d v=0", k, evt_count, evt_valid, exp_count);
      else passes++;
      checks++;
      if (log_q.size() - base != 3)
        $display("FAIL ev%0d_nxact got %0d want 3", k, log_q.size() - base);
      else passes++;
      if (log_q.size() - base == 3) begin
        checks++;
        if (log_q[base].wr !== 1'b0 || log_q[base].a !== 2'd3 ||
            log_q[base+1].wr !== 1'b1 || log_q[base+1].a !== 2'd3 ||
            log_q[base+1].d !== 32'(e) ||
            log_q[base+2].wr !== 1'b0 || log_q[base+2].a !== 2'd0)
          $display("FAIL ev%0d_seq got %0d/%0d %0d/%0d/%h %0d/%0d want 0/3 1/3/%h 0/0", k,
                   log_q[base].wr, log_q[base].a, log_q[base+1].wr, log_q[base+1].a,
                   log_q[base+1].d, log_q[base+2].wr, log_q[base+2].a, 32'(e));
        else passes++;
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] e;
    int s0;
    bit ok;
    e = W'($urandom_range(1, (1 << W) - 1));
    lvl = W'($urandom());
    s0 = stab_err;
    stall_cfg = 3;
    inject(e);
    wait_valid(60, ok);
    checks++;
    if (!ok || vrise - irq_rise != 4 + 2 * L + 9)
      $display("FAIL stall_lat got ok=%0d lat=%0d want %0d", ok, vrise - irq_rise, 4 + 2 * L + 9);
    else passes++;
    checks++;
    if (stab_err != s0) $display("FAIL stall_stable got %0d errs want 0", stab_err - s0);
    else passes++;
    checks++;
    if (evt_edges !== e || evt_level !== lvl)
      $display("FAIL stall_data got e=%h l=%h want e=%h l=%h", evt_edges, evt_level, e, lvl);
    else passes++;
    stall_cfg = 0;
    @(negedge clk);
    exp_count++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_spurious();
    int base, vr0;
    base = log_q.size();
    vr0 = vrise;
    force_irq = 1'b1;
    @(negedge clk);
    force_irq = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (log_q.size() - base != 1)
      $display("FAIL spur_nxact got %0d want 1", log_q.size() - base);
    else passes++;
    if (log_q.size() - base == 1) begin
      checks++;
      if (log_q[base].wr !== 1'b0 || log_q[base].a !== 2'd3)
        $display("FAIL spur_rd got wr=%0d a=%0d want wr=0 a=3", log_q[base].wr, log_q[base].a);
      else passes++;
    end
    checks++;
    if (vrise != vr0 || evt_valid !== 1'b0 || evt_count !== exp_count)
      $display("FAIL spur_noevt got v=%b c=%0d want v=0 c=%0d", evt_valid, evt_count, exp_count);
    else passes++;
  endtask

  task automatic test_backpressure_mask();
    logic [W-1:0] e, lv;
    int base, h0;
    bit ok;
    e = W'($urandom_range(1, (1 << W) - 1));
    lv = W'($urandom());
    lvl = lv;
    evt_ready = 1'b0;
    base = log_q.size();
    inject(e);
    wait_valid(40, ok);
    checks++;
    if (!ok) $display("FAIL bp_timeout got no evt_valid want evt_valid");
    else passes++;
    h0 = hold_err;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cfg_mask_wr = (i == 2) || (i == 5);
      cfg_mask = (i == 2) ? W'(5) : W'(3);
    end
    checks++;
    if (evt_valid !== 1'b1 || evt_edges !== e || evt_level !== lv || hold_err != h0)
      $display("FAIL bp_hold got v=%b e=%h l=%h herr=%0d want v=1 e=%h l=%h herr=0",
               evt_valid, evt_edges, evt_level, hold_err - h0, e, lv);
    else passes++;
    evt_ready = 1'b1;
    inject(W'(1));
    @(negedge clk);
    exp_count++;
    checks++;
    if (evt_count !== exp_count) $display("FAIL bp_count got %0d want %0d", evt_count, exp_count);
    else passes++;
    wait_valid(40, ok);
    checks++;
    if (!ok || evt_edges !== W'(1))
      $display("FAIL bp_next got ok=%0d e=%h want ok=1 e=1", ok, evt_edges);
    else passes++;
    checks++;
    if (log_q.size() - base < 5)
      $display("FAIL bp_nxact got %0d want >=5", log_q.size() - base);
    else passes++;
    if (log_q.size() - base >= 5) begin
      checks++;
      if (log_q[base+3].wr !== 1'b1 || log_q[base+3].a !== 2'd2 || log_q[base+3].d !== 32'd3 ||
          log_q[base+4].wr !== 1'b0 || log_q[base+4].a !== 2'd3)
        $display("FAIL bp_maskfirst got %0d/%0d/%h %0d/%0d want 1/2/3 0/3",
                 log_q[base+3].wr, log_q[base+3].a, log_q[base+3].d,
                 log_q[base+4].wr, log_q[base+4].a);
      else passes++;
    end
    @(negedge clk);
    exp_count++;
    cfg_mask = ALL1;
    cfg_mask_wr = 1'b1;
    @(negedge clk);
    cfg_mask_wr = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (pio_mask !== ALL1) $display("FAIL bp_restore got %h want %h", pio_mask, ALL1);
    else passes++;
  endtask

  task automatic test_reset_mid_clr();
    logic [W-1:0] e;
    int base, rel;
    bit seen, ok;
    e = W'($urandom_range(1, (1 << W) - 1));
    lvl = W'($urandom());
    stall_cfg = 2;
    evt_ready = 1'b1;
    inject(e);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = avm_write && (avm_address == 2'd3);
    end
    checks++;
    if (!seen) $display("FAIL rc_clr_timeout got no CLR write want CLR write");
    else passes++;
    reset = 1'b1;
    #1;
    checks++;
    if ({avm_read, avm_write, avm_address, avm_writedata} !== 36'd0 ||
        {evt_valid, evt_edges, evt_level, evt_count} !== '0)
      $display("FAIL rc_zero got bus=%h v=%b e=%h l=%h c=%h want 0",
               {avm_read, avm_write, avm_address, avm_writedata},
               evt_valid, evt_edges, evt_level, evt_count);
    else passes++;
    stall_cfg = 0;
    base = log_q.size();
    @(negedge clk);
    reset = 1'b0;
    rel = cyc;
    exp_count = 16'd0;
    wait_valid(40, ok);
    checks++;
    if (log_q.size() - base < 1 || log_q[base].wr !== 1'b1 || log_q[base].a !== 2'd2 ||
        log_q[base].d !== 32'(ALL1) || log_q[base].c != rel + 1)
      $display("FAIL rc_maskwr got n=%0d want mask write %h at +1", log_q.size() - base, ALL1);
    else passes++;
    checks++;
    if (!ok || evt_edges !== e)
      $display("FAIL rc_evt got ok=%0d e=%h want ok=1 e=%h", ok, evt_edges, e);
    else passes++;
    @(negedge clk);
    exp_count++;
    checks++;
    if (evt_count !== exp_count) $display("FAIL rc_count got %0d want %0d", evt_count, exp_count);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_event();
    test_stall();
    test_spurious();
    test_backpressure_mask();
    test_reset_mid_clr();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/de2_115_web_qsys_pio_irq_master.md
# de2_115_web_qsys_pio_irq_master

Avalon-MM master that services the edge-capturing switch PIO on its interrupt, replacing the Nios II interrupt handler for that peripheral. On reset it programs the PIO interrupt mask, then waits for `irq`. On each interrupt it reads the edge-capture register, clears it, reads the live input level, and presents one event on a valid/ready stream to the downstream Ethernet/ROS message logic. It sits on the Qsys fabric as a master, with its single slave being the switch PIO.

## Interface
Parameters:
- `WIDTH`, 18: PIO input width in bits; legal range 1..32.
- `READ_LATENCY`, 1: fixed slave read latency in cycles; legal range 1..4.
- `MASK_INIT`, all ones (`WIDTH` bits): interrupt mask written to the PIO after reset.

Ports:
- `clk`  in  1: single clock for the whole block.
- `reset`  in  1: **reset is asynchronous and active-high**.
- `irq`  in  1: PIO interrupt, level-sensitive.
- `avm_address`  out  2: PIO word address.
- `avm_read`  out  1: read request.
- `avm_write`  out  1: write request.
- `avm_writedata`  out  32: write data; bits above `WIDTH` are driven 0.
- `avm_readdata`  in  32: read data; only bits `[WIDTH-1:0]` are used.
- `avm_waitrequest`  in  1: slave stall; tie to 0 if the slave has none.
- `cfg_mask_wr`  in  1: one-cycle pulse requesting a new mask.
- `cfg_mask`  in  `WIDTH`: new mask value, sampled when `cfg_mask_wr` is 1.
- `evt_valid`  out  1: event available.
- `evt_ready`  in  1: downstream accepts the event.
- `evt_edges`  out  `WIDTH`: captured falling edges.
- `evt_level`  out  `WIDTH`: input level read after the clear.
- `evt_count`  out  16: number of accepted events, wraps modulo 2^16.

## Operation
- PIO addresses: 0 = data, 2 = irq mask, 3 = edge capture. Any write to address 3 clears **all** capture bits in the PIO.
- FSM states:
  - `INIT`: write the mask register (address 2), then go to `IDLE`.
  - `IDLE`: if a mask update is pending, go to `INIT`; otherwise, if `irq`=1, go to `RD_CAP`.
  - `RD_CAP`: read address 3. Wait `READ_LATENCY` cycles, latch the result into the edges register. If the result is 0, go to `IDLE` (spurious interrupt, no event). Otherwise go to `CLR`.
  - `CLR`: write address 3 with the captured edges, then go to `RD_DAT`.
  - `RD_DAT`: read address 0, latch the result into the level register, then go to `EMIT`.
  - `EMIT`: assert `evt_valid` until `evt_valid && evt_ready`. On the handshake, increment `evt_count` and go to `IDLE`.
- Mask updates:
  - `cfg_mask_wr` may arrive in any state. It is stored as pending and applied only from `IDLE`.
  - A second pulse before the update is applied overwrites the stored value (last value wins).
  - `INIT` uses `MASK_INIT` after reset and the pending value afterwards.
- Transfer rule:
  - `avm_address`, `avm_read`, `avm_write` and `avm_writedata` stay stable while `avm_waitrequest`=1.
  - A transfer is accepted in the cycle where the request is high and `avm_waitrequest`=0.
  - Read data is sampled exactly `READ_LATENCY` cycles after acceptance.
  - `avm_read` and `avm_write` are never high in the same cycle.
  - Each request is high for one accepted cycle only.
- An edge that arrives between acceptance of the `RD_CAP` read and acceptance of the `CLR` write is lost. This is a PIO limitation and is documented, not corrected.
- While `evt_valid`=1, `evt_edges` and `evt_level` are held stable.

## Timing
- Reset values: `avm_read`, `avm_write` and `evt_valid` are 0; `avm_address`, `avm_writedata`, `evt_edges`, `evt_level` and `evt_count` are 0; the pending mask flag is cleared; the FSM is in `INIT`.
- Reset asserted mid-transfer abandons the transfer immediately. On release, the block restarts at `INIT` and rewrites `MASK_INIT`.
- First mask write: `avm_write`=1 on the first clock edge after reset deasserts.
- Latency with `avm_waitrequest`=0: `irq` is sampled high in `IDLE` at cycle 0, and `evt_valid` rises at cycle 4+2·`READ_LATENCY` (cycle 6 when `READ_LATENCY`=1). Every cycle of `avm_waitrequest`=1 adds one cycle.
- `irq` is ignored outside `IDLE`. After `CLR`, the PIO drops `irq` one cycle after the write is accepted, before the FSM returns to `IDLE`.
- `evt_count` updates in the cycle after the handshake. It wraps from 0xFFFF to 0x0000.

## Structure
- Shared package `de2_115_web_qsys_pio_pkg` holds:
  - the PIO address constants (`PIO_ADDR_DATA`, `PIO_ADDR_MASK`, `PIO_ADDR_EDGE`);
  - the FSM state enum;
  - the `WIDTH` default.
- Sub-module `de2_115_web_qsys_avm_xfer` is a single-transfer Avalon master engine. It takes start/read-or-write/address/data, handles `avm_waitrequest` and the `READ_LATENCY` countdown, and returns a `done` pulse plus read data. The top level holds the FSM, the event registers and the mask-pending logic.

## Test plan
- Reset release, `avm_waitrequest`=0 → one write to address 2 with data 0x3FFFF on cycle 1, then idle with no further bus activity.
- `irq` high, PIO returns edges 0x00005 and then level 0x3FFFA, `evt_ready`=1 → bus sequence read 3, write 3 (0x00005), read 0. `evt_valid` rises at cycle 6 with edges 0x00005 and level 0x3FFFA; `evt_count`=1.
- `avm_waitrequest` held high for 3 cycles on each transfer → requests stay stable while stalled, and `evt_valid` rises at cycle 15.
- Edge read returns 0 → no write, no event, FSM back in `IDLE`, `evt_count` unchanged.
- `evt_ready` low for 10 cycles during `EMIT`, with a `cfg_mask_wr`=0x00003 pulse meanwhile → event data held stable; after the handshake, a write of 0x00003 to address 2 occurs before the next interrupt is serviced.
- Reset pulse in the middle of `CLR` → all outputs 0 immediately; after release, the `MASK_INIT` write is reissued and `evt_count`=0.
